// File: rtl/hash_des_pkg.sv
// Shared types, constants and bit-level helpers for the DES S-box stream hash.
// Lane i of an hstate_t holds H[i]; pack_digest() places H[0] in the top nibble.
package hash_des_pkg;

    typedef logic [7:0][3:0] hstate_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ROUND,
        FINAL
    } state_e;

    // H[0]..H[7] = 4,B,7,1,D,F,0,3; lane 0 sits in the low nibble of the packed value.
    localparam hstate_t H_INIT = 32'h30FD_17B4;

    // DES S5 rows, column 0 in the most significant nibble.
    localparam logic [63:0] S5_ROW0 = 64'h2C41_7AB6_853F_D0E9;
    localparam logic [63:0] S5_ROW1 = 64'hEB2C_47D1_50FA_3986;
    localparam logic [63:0] S5_ROW2 = 64'h421B_AD78_F9C5_630E;
    localparam logic [63:0] S5_ROW3 = 64'hB8C7_1E2D_6F09_A453;

    function automatic logic [3:0] sbox_s5(input logic [5:0] x);
        logic [63:0] row_bits;
        logic [63:0] shifted;
        int unsigned sh;
        row_bits = S5_ROW0;
        unique case ({x[5], x[0]})
            2'b00: row_bits = S5_ROW0;
            2'b01: row_bits = S5_ROW1;
            2'b10: row_bits = S5_ROW2;
            2'b11: row_bits = S5_ROW3;
        endcase
        sh = 4 * (15 - 32'(x[4:1]));
        shifted = row_bits >> sh;
        return shifted[3:0];
    endfunction

    function automatic logic [5:0] m_to_m6(input logic [7:0] m);
        return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
    endfunction

    function automatic logic [5:0] c_to_c6(input logic [7:0] c);
        return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input int n);
        logic [7:0] dbl;
        dbl = {x, x} << n;
        return dbl[7:4];
    endfunction

    function automatic logic [31:0] pack_digest(input hstate_t h);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[31 - 4 * i -: 4] = h[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/hash_des_round.sv
// One combinational hash round: every lane takes its right neighbour XOR its own S value,
// rotated left by lane/2. Rounds pass the same S on all lanes; the final step does not.
module hash_des_round
    import hash_des_pkg::*;
(
    input  hstate_t h_i,
    input  hstate_t s_i,
    output hstate_t h_o
);

    always_comb begin
        h_o = '0;
        for (int i = 0; i < 8; i++) begin
            h_o[i] = rotl4(h_i[(i + 1) % 8] ^ s_i[i], i / 2);
        end
    end

endmodule

// File: rtl/hash_des_sbox_stream.sv
// Handshaked byte-stream engine for the DES S-box hash: ROUNDS rounds per byte, UNROLL per
// clock, followed by a length-mixing step that produces the 32-bit digest.
module hash_des_sbox_stream
    import hash_des_pkg::*;
#(
    parameter int unsigned ROUNDS = 4,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned LEN_W  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic             msg_valid_i,
    input  logic [7:0]       msg_data_i,
    output logic             msg_ready_o,
    output logic             busy_o,
    output logic [31:0]      digest_o,
    output logic             digest_valid_o
);

    localparam int unsigned ROUND_CYC = ROUNDS / UNROLL;
    localparam int unsigned CNT_W     = (ROUND_CYC > 1) ? $clog2(ROUND_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUND_CYC - 1);

    if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("hash_des_sbox_stream: UNROLL must be >= 1 and divide ROUNDS (>= 1)");
    end
    if (LEN_W < 8 || LEN_W > 64 || (LEN_W % 8) != 0) begin : g_bad_len_w
        $error("hash_des_sbox_stream: LEN_W must be a multiple of 8 in 8..64");
    end

    state_e           state_q, state_d;
    hstate_t          h_q, h_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [3:0]       s_q, s_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [31:0]      digest_q, digest_d;
    logic             dv_q, dv_d;

    hstate_t          round_h;
    hstate_t          final_s;
    hstate_t          final_h;
    logic [63:0]      len64;

    // Round chain: UNROLL copies of the lane logic, all sharing the latched byte S value.
    for (genvar u = 0; u < UNROLL; u++) begin : g_unroll
        hstate_t h_in;
        hstate_t h_out;
        if (u == 0) begin : g_first
            assign h_in = h_q;
        end else begin : g_next
            assign h_in = g_unroll[u-1].h_out;
        end
        hash_des_round u_round (
            .h_i (h_in),
            .s_i ({8{s_q}}),
            .h_o (h_out)
        );
    end
    assign round_h = g_unroll[UNROLL-1].h_out;

    // Length mixing: lane k takes byte k of the zero-extended length, most significant first.
    assign len64 = 64'(len_q);

    always_comb begin
        final_s = '0;
        for (int k = 0; k < 8; k++) begin
            final_s[k] = sbox_s5(c_to_c6(len64[63 - 8 * k -: 8]));
        end
    end

    hash_des_round u_final (
        .h_i (h_q),
        .s_i (final_s),
        .h_o (final_h)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_i) state_d = (msg_len_i == '0) ? FINAL : WAIT;
            WAIT:  if (msg_valid_i) state_d = ROUND;
            ROUND: if (rcnt_q == LAST_CNT) state_d = (rem_q != '0) ? WAIT : FINAL;
            FINAL: state_d = IDLE;
        endcase
    end

    always_comb begin
        msg_ready_o = (state_q == WAIT);
        busy_o      = (state_q != IDLE);
    end

    always_comb begin
        h_d      = h_q;
        rem_d    = rem_q;
        len_d    = len_q;
        s_d      = s_q;
        rcnt_d   = rcnt_q;
        digest_d = digest_q;
        dv_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    h_d   = H_INIT;
                    rem_d = msg_len_i;
                    len_d = msg_len_i;
                end
            end
            WAIT: begin
                if (msg_valid_i) begin
                    s_d    = sbox_s5(m_to_m6(msg_data_i));
                    rem_d  = rem_q - 1'b1;
                    rcnt_d = '0;
                end
            end
            ROUND: begin
                h_d    = round_h;
                rcnt_d = rcnt_q + 1'b1;
            end
            FINAL: begin
                h_d      = final_h;
                digest_d = pack_digest(final_h);
                dv_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            s_q      <= '0;
            rcnt_q   <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            s_q      <= s_d;
            rcnt_q   <= rcnt_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
        end
    end

    assign digest_o       = digest_q;
    assign digest_valid_o = dv_q;

endmodule

// File: tb/tb_hash_des_sbox_stream.sv
// Directed bench: three engines (UNROLL 1, 2, 4) run zero-length and "abc" messages, plus
// an S5 table sweep, valid gaps and an asynchronous reset mid-message.
module tb_hash_des_sbox_stream;
    import hash_des_pkg::*;

    localparam int NDUT = 3;
    localparam logic [31:0] DIG_EMPTY = 32'h956F_7883;
    localparam logic [31:0] DIG_ABC   = 32'hB115_FC50;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] msg_len;
    logic        start  [NDUT];
    logic        valid  [NDUT];
    logic        ready  [NDUT];
    logic        busy   [NDUT];
    logic        dv     [NDUT];
    logic [31:0] digest [NDUT];

    int acc_cnt  [NDUT];
    int acc_base [NDUT];
    int dv_cnt   [NDUT];
    int dv_cyc   [NDUT];
    int rdy_cnt  [NDUT];
    int dv_base  [NDUT];
    int rdy_base [NDUT];

    logic [7:0] msg_bytes [3];
    int         s5_gold [4][16];
    int         exp_off [NDUT];
    int         cyc = 0;
    int         c0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [7:0] data_g;
        int acc_g    = 0;
        int dv_cnt_g = 0;
        int dv_cyc_g = 0;
        int rdy_g    = 0;

        always @* begin
            int k;
            k = acc_g - acc_base[g];
            data_g = (k >= 0 && k < 3) ? msg_bytes[k] : 8'h00;
        end

        always @(posedge clk) if (valid[g] && ready[g]) acc_g <= acc_g + 1;

        always @(negedge clk) begin
            if (dv[g]) begin
                dv_cnt_g <= dv_cnt_g + 1;
                dv_cyc_g <= cyc;
            end
            if (ready[g]) rdy_g <= rdy_g + 1;
        end

        assign acc_cnt[g] = acc_g;
        assign dv_cnt[g]  = dv_cnt_g;
        assign dv_cyc[g]  = dv_cyc_g;
        assign rdy_cnt[g] = rdy_g;

        hash_des_sbox_stream #(
            .ROUNDS (4),
            .UNROLL (1 << g),
            .LEN_W  (64)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start_i        (start[g]),
            .msg_len_i      (msg_len),
            .msg_valid_i    (valid[g]),
            .msg_data_i     (data_g),
            .msg_ready_o    (ready[g]),
            .busy_o         (busy[g]),
            .digest_o       (digest[g]),
            .digest_valid_o (dv[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        for (int g = 0; g < NDUT; g++) begin
            acc_base[g] = acc_cnt[g];
            dv_base[g]  = dv_cnt[g];
            rdy_base[g] = rdy_cnt[g];
        end
    endtask

    initial begin
        int r;
        int c;
        int n;

        s5_gold = '{'{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
                    '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
                    '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
                    '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}};
        exp_off = '{17, 11, 8};
        msg_bytes[0] = 8'h61;
        msg_bytes[1] = 8'h62;
        msg_bytes[2] = 8'h63;

        rst     = 1'b1;
        msg_len = '0;
        for (int g = 0; g < NDUT; g++) begin
            start[g]    = 1'b0;
            valid[g]    = 1'b0;
            acc_base[g] = 0;
        end
        repeat (2) @(negedge clk);

        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("rst busy u%0d", g), 32'(busy[g]), 32'd0);
            check_eq($sformatf("rst ready u%0d", g), 32'(ready[g]), 32'd0);
            check_eq($sformatf("rst digest u%0d", g), digest[g], 32'h0);
            check_eq($sformatf("rst dvalid u%0d", g), 32'(dv[g]), 32'd0);
        end

        check_eq("sbox 010111", 32'(sbox_s5(6'b010111)), 32'hA);
        check_eq("sbox 101000", 32'(sbox_s5(6'b101000)), 32'hA);
        check_eq("sbox 111001", 32'(sbox_s5(6'b111001)), 32'hA);
        for (int x = 0; x < 64; x++) begin
            r = ((x >> 4) & 2) | (x & 1);
            c = (x >> 1) & 15;
            check_eq($sformatf("sbox sweep %0d", x), 32'(sbox_s5(6'(x))), 32'(s5_gold[r][c]));
        end

        tick();
        rst = 1'b0;
        tick();

        // Zero-length message on all three engines.
        snapshot();
        msg_len = 64'd0;
        for (int g = 0; g < NDUT; g++) start[g] = 1'b1;
        c0 = cyc;
        tick();
        for (int g = 0; g < NDUT; g++) start[g] = 1'b0;
        repeat (6) tick();
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("empty pulses u%0d", g), 32'(dv_cnt[g] - dv_base[g]), 32'd1);
            check_eq($sformatf("empty dv cycle u%0d", g), 32'(dv_cyc[g] - c0), 32'd2);
            check_eq($sformatf("empty digest u%0d", g), digest[g], DIG_EMPTY);
            check_eq($sformatf("empty ready u%0d", g), 32'(rdy_cnt[g] - rdy_base[g]), 32'd0);
        end

        // "abc" with msg_valid held high.
        snapshot();
        msg_len = 64'd3;
        for (int g = 0; g < NDUT; g++) begin
            start[g] = 1'b1;
            valid[g] = 1'b1;
        end
        c0 = cyc;
        tick();
        for (int g = 0; g < NDUT; g++) start[g] = 1'b0;
        repeat (25) tick();
        for (int g = 0; g < NDUT; g++) valid[g] = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("abc pulses u%0d", g), 32'(dv_cnt[g] - dv_base[g]), 32'd1);
            check_eq($sformatf("abc dv cycle u%0d", g), 32'(dv_cyc[g] - c0), 32'(exp_off[g]));
            check_eq($sformatf("abc digest u%0d", g), digest[g], DIG_ABC);
            check_eq($sformatf("abc bytes u%0d", g), 32'(acc_cnt[g] - acc_base[g]), 32'd3);
        end

        // "abc" on engine 0 with three idle cycles before each byte.
        snapshot();
        msg_len  = 64'd3;
        start[0] = 1'b1;
        c0 = cyc;
        tick();
        start[0] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (!ready[0] && n < 20) begin
                tick();
                n++;
            end
            check_eq($sformatf("gap ready byte %0d", b), 32'(ready[0]), 32'd1);
            repeat (3) tick();
            valid[0] = 1'b1;
            tick();
            valid[0] = 1'b0;
        end
        repeat (6) tick();
        check_eq("gap pulses", 32'(dv_cnt[0] - dv_base[0]), 32'd1);
        check_eq("gap dv cycle", 32'(dv_cyc[0] - c0), 32'd26);
        check_eq("gap digest", digest[0], DIG_ABC);
        check_eq("gap bytes", 32'(acc_cnt[0] - acc_base[0]), 32'd3);

        // Asynchronous reset during the rounds of byte 2.
        snapshot();
        msg_len  = 64'd3;
        start[0] = 1'b1;
        valid[0] = 1'b1;
        c0 = cyc;
        tick();
        start[0] = 1'b0;
        while (cyc < c0 + 8) tick();
        check_eq("mid busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst busy", 32'(busy[0]), 32'd0);
        check_eq("arst ready", 32'(ready[0]), 32'd0);
        check_eq("arst digest", digest[0], 32'h0);
        check_eq("arst dvalid", 32'(dv[0]), 32'd0);
        valid[0] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (25) tick();
        check_eq("arst no pulse", 32'(dv_cnt[0] - dv_base[0]), 32'd0);

        snapshot();
        msg_len  = 64'd0;
        start[0] = 1'b1;
        c0 = cyc;
        tick();
        start[0] = 1'b0;
        repeat (6) tick();
        check_eq("post-rst dv cycle", 32'(dv_cyc[0] - c0), 32'd2);
        check_eq("post-rst digest", digest[0], DIG_EMPTY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
